// File: rtl/spi_frame_assembler_if.sv
// rtl/spi_frame_assembler_if.sv - byte-stream input and frame handshake bundle for the frame assembler
interface spi_frame_assembler_if #(
  parameter int BYTES = 3
) ();
  logic [7:0]         spi_data;
  logic               spi_data_valid;
  logic [8*BYTES-1:0] frame_data;
  logic               frame_valid;
  logic               frame_ready;
  logic               short_err;
  logic               overflow_err;
  logic               discard_err;

  // Drives bytes in and consumes frames
  modport master (
    output spi_data, spi_data_valid, frame_ready,
    input  frame_data, frame_valid, short_err, overflow_err, discard_err
  );

  // The assembler itself
  modport slave (
    input  spi_data, spi_data_valid, frame_ready,
    output frame_data, frame_valid, short_err, overflow_err, discard_err
  );
endinterface

// File: rtl/spi_frame_assembler.sv
// rtl/spi_frame_assembler.sv - groups SPI bytes into BYTES-long frames with a one-deep valid/ready output
module spi_frame_assembler #(
  parameter int BYTES       = 3,
  parameter bit STREAM      = 1'b0,
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic spi_cs_n_in,
  spi_frame_assembler_if.slave bus
);
  localparam int FW = 8 * BYTES;
  // Buffer keeps a dummy byte when BYTES=1 so the declaration stays legal; it is never shifted then
  localparam int BW = (BYTES > 1) ? 8 * (BYTES - 1) : 8;
  localparam int CW = $clog2(BYTES + 1);
  localparam logic [CW-1:0] LAST = CW'(BYTES - 1);

  typedef enum logic [1:0] {IDLE, ACTIVE, DISCARD} state_t;

  state_t                 state;
  logic [SYNC_STAGES-1:0] cs_sync;
  logic                   cs_n_s;
  logic [BW-1:0]          buffer;
  logic [CW-1:0]          count;
  logic                   completes;
  logic [CW-1:0]          count_upd;
  logic [FW-1:0]          assembled;

  assign cs_n_s = cs_sync[SYNC_STAGES-1];

  // Bring the raw chip select into the clk domain; reset to deasserted
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cs_sync <= '1;
    else        cs_sync <= {cs_sync[SYNC_STAGES-2:0], spi_cs_n_in};
  end

  // Byte accounting for this cycle: the byte is taken before any CS decision
  always_comb begin
    completes = (state == ACTIVE) && bus.spi_data_valid && (count == LAST);
    count_upd = count;
    if ((state == ACTIVE) && bus.spi_data_valid)
      count_upd = completes ? '0 : count + CW'(1);
    // Truncation keeps the low FW bits: buffer bytes followed by the incoming byte
    assembled = FW'({buffer, bus.spi_data});
  end

  // Framing state machine with the output holding register and error pulses
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state            <= IDLE;
      count            <= '0;
      buffer           <= '0;
      bus.frame_data   <= '0;
      bus.frame_valid  <= 1'b0;
      bus.short_err    <= 1'b0;
      bus.overflow_err <= 1'b0;
      bus.discard_err  <= 1'b0;
    end else begin
      bus.short_err    <= 1'b0;
      bus.overflow_err <= 1'b0;
      bus.discard_err  <= 1'b0;

      // Consumer handshake; a completion below may reload in the same cycle
      if (bus.frame_valid && bus.frame_ready) bus.frame_valid <= 1'b0;

      case (state)
        IDLE: begin
          count <= '0;
          if (!cs_n_s) state <= ACTIVE;
        end
        ACTIVE: begin
          if (bus.spi_data_valid && !completes)
            buffer <= BW'({buffer, bus.spi_data});
          if (completes) begin
            if (!bus.frame_valid || bus.frame_ready) begin
              bus.frame_data  <= assembled;
              bus.frame_valid <= 1'b1;
            end else begin
              // Holding register still owned by the consumer: keep the old frame
              bus.overflow_err <= 1'b1;
            end
          end
          if (cs_n_s) begin
            state <= IDLE;
            count <= '0;
            if (count_upd != '0) bus.short_err <= 1'b1;
          end else begin
            count <= count_upd;
            if (completes && !STREAM) state <= DISCARD;
          end
        end
        DISCARD: begin
          if (bus.spi_data_valid) bus.discard_err <= 1'b1;
          if (cs_n_s) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
